fetch_unit: RTL and testbench

//  Instruction fetch stage sitting directly upstream of the instruction decoder.

---
 rtl/fetch_unit.sv | 137 +++++++++++++
 tb/tb_fetch_unit.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding 32-bit read at a
// time, and buffers returned words with their PCs in a small FIFO. The FIFO head
// is presented on a registered valid/ready interface to the decoder. Branch/jump
// redirects flush the FIFO and restart fetch, draining any in-flight read first.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h6000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_address,
  output logic        imem_read,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

  typedef enum logic {
    FETCH,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_t         state;
  logic [31:0]    pc;
  logic [31:0]    pc_plus4;
  logic [31:0]    redirect_aligned;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_n;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_n;
  logic           push;
  logic           pop;
  entry_t         head_n;
  entry_t         queue_mem [QUEUE_DEPTH];

  assign pc_plus4         = pc + 32'd4;
  assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

  // Next-cycle FIFO occupancy and head entry; a redirect flushes and masks push/pop.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    push     = (state == FETCH) && imem_read && imem_resp && !redirect_valid;
    pop      = out_valid && out_ready && !redirect_valid;
    count_n  = count;
    rd_ptr_n = rd_ptr;
    if (redirect_valid) begin
      count_n = '0;
    end else begin
      count_n = count + CNT_W'(push) - CNT_W'(pop);
      if (pop) rd_ptr_n = rd_ptr + PTR_W'(1);
    end
    // The new head is the word arriving this cycle when it lands in the head slot.
    if (push && (wr_ptr == rd_ptr_n)) head_n = '{pc: pc, instr: imem_rdata};
    else                              head_n = queue_mem[rd_ptr_n];
  end

  // FIFO storage write; only entries between rd_ptr and wr_ptr are ever read.
  always_ff @(posedge clk) begin
    // NOTE: storage array has no reset; occupancy is tracked by count, so stale data is never presented.
    if (push) queue_mem[wr_ptr] <= '{pc: pc, instr: imem_rdata};
  end

  // FIFO pointers and registered output stage mirroring the next head.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_instr <= 32'h0;
      out_pc    <= 32'h0;
    end else begin
      count  <= count_n;
      rd_ptr <= rd_ptr_n;
      if (redirect_valid) wr_ptr <= rd_ptr_n;
      else if (push)      wr_ptr <= wr_ptr + PTR_W'(1);
      out_valid <= (count_n != '0);
      if (count_n != '0) begin
        out_pc    <= head_n.pc;
        out_instr <= head_n.instr;
      end
    end
  end

  // Fetch FSM: issues reads with space reserved, advances the PC, handles redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      imem_read    <= 1'b0;
      imem_address <= RESET_PC;
    end else begin
      case (state)
        FETCH: begin
          if (redirect_valid) begin
            pc <= redirect_aligned;
            if (imem_read && !imem_resp) state <= DRAIN;
            else                         imem_read <= 1'b0;
          end else if (imem_read) begin
            if (imem_resp) begin
              pc        <= pc_plus4;
              imem_read <= 1'b0;
            end
          end else if (count_n < DEPTH_C) begin
            imem_read    <= 1'b1;
            imem_address <= pc;
          end
        end
        DRAIN: begin
          if (redirect_valid) pc <= redirect_aligned;
          if (imem_resp) begin
            imem_read <= 1'b0;
            state     <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a behavioural instruction memory with
// programmable latency, a scoreboard of expected {pc, word} pairs popped as the
// decoder side accepts them, and one task per scenario.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h6000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_address;
  logic        imem_read;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_resp = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] iss_q[$];
  exp_t        mon_e;
  int          n_tests = 0;
  int          n_fail = 0;
  int          mem_lat = 1;
  bit          mem_hold = 1'b0;
  bit          pending = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] p_addr = 32'h0;
  int          issued = 0;
  bit          ready_en = 1'b0;
  bit          force_ready = 1'b0;

  fetch_unit #(.RESET_PC(RESET_PC), .QUEUE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_address(imem_address), .imem_read(imem_read),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Instruction memory model: accepts a read, checks it is held, responds after mem_lat.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      imem_resp = 1'b0;
      if (!rst_n) begin
        pending = 1'b0;
      end else if (pending) begin
        n_tests++;
        if (imem_read !== 1'b1 || imem_address !== p_addr) begin
          n_fail++;
          $display("FAIL imem_hold: read=%b addr=%h, want read=1 addr=%h", imem_read, imem_address, p_addr);
        end
        if (!mem_hold) begin
          if (mem_cnt <= 1) begin
            imem_resp  = 1'b1;
            imem_rdata = word_of(p_addr);
            pending    = 1'b0;
          end else begin
            mem_cnt--;
          end
        end
      end else if (imem_read === 1'b1) begin
        pending = 1'b1;
        p_addr  = imem_address;
        mem_cnt = mem_lat;
        issued++;
        iss_q.push_back(imem_address);
        if (!mem_hold && mem_cnt <= 1) begin
          imem_resp  = 1'b1;
          imem_rdata = word_of(p_addr);
          pending    = 1'b0;
        end
      end
    end
  end

  // Decoder-side model: drives out_ready and compares every accepted head to the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      out_ready = force_ready || (ready_en && sb_q.size() != 0);
      if (rst_n && out_valid && out_ready && !redirect_valid) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pop: got pc=%h instr=%h, want no output", out_pc, out_instr);
        end else begin
          mon_e = sb_q.pop_front();
          if (out_pc !== mon_e.pc || out_instr !== mon_e.instr) begin
            n_fail++;
            $display("FAIL out_word: got pc=%h instr=%h, want pc=%h instr=%h",
                     out_pc, out_instr, mon_e.pc, mon_e.instr);
          end
        end
      end
    end
  end

  task automatic expect_word(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = word_of(pc);
    sb_q.push_back(e);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    rst_n          = 1'b0;
    ready_en       = 1'b0;
    force_ready    = 1'b0;
    mem_hold       = 1'b0;
    redirect_valid = 1'b0;
    sb_q.delete();
    repeat (3) @(posedge clk);
    #2;
    iss_q.delete();
    issued = 0;
    rst_n  = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300 && sb_q.size() != 0; i++) @(posedge clk);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d words still expected, want 0", name, sb_q.size());
      sb_q.delete();
    end
    #2;
    ready_en = 1'b0;
  endtask

  task automatic wait_iss(input int n, input string name);
    for (int i = 0; i < 300 && iss_q.size() < n; i++) @(posedge clk);
    n_tests++;
    if (iss_q.size() < n) begin
      n_fail++;
      $display("FAIL %s_issue_timeout: %0d requests seen, want %0d", name, iss_q.size(), n);
    end
  endtask

  task automatic wait_out_valid(input string name);
    int i;
    for (i = 0; i < 100; i++) begin
      @(posedge clk);
      #2;
      if (out_valid === 1'b1) break;
    end
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_valid_timeout: out_valid=%b, want 1", name, out_valid);
    end
  endtask

  task automatic wait_pending(input string name);
    int i;
    for (i = 0; i < 100; i++) begin
      @(posedge clk);
      #2;
      if (pending) break;
    end
    n_tests++;
    if (!pending) begin
      n_fail++;
      $display("FAIL %s_req_timeout: no outstanding request, want one", name);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_tests++;
    if (imem_read !== 1'b0 || imem_address !== RESET_PC) begin
      n_fail++;
      $display("FAIL reset_imem: read=%b addr=%h, want read=0 addr=%h", imem_read, imem_address, RESET_PC);
    end
    n_tests++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_out: valid=%b instr=%h pc=%h, want 0 0 0", out_valid, out_instr, out_pc);
    end
    iss_q.delete();
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    n_tests++;
    if (imem_read !== 1'b1 || imem_address !== RESET_PC) begin
      n_fail++;
      $display("FAIL first_issue: read=%b addr=%h, want read=1 addr=%h", imem_read, imem_address, RESET_PC);
    end
  endtask

  task automatic test_stream();
    apply_reset();
    mem_lat = 1;
    expect_word(32'h6000_0000);
    expect_word(32'h6000_0004);
    expect_word(32'h6000_0008);
    ready_en = 1'b1;
    wait_drain("stream");
  endtask

  task automatic test_backpressure();
    apply_reset();
    mem_lat = 2;
    repeat (20) @(posedge clk);
    #2;
    n_tests++;
    if (issued !== DEPTH || imem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_issue: issued=%0d read=%b, want issued=%0d read=0", issued, imem_read, DEPTH);
    end
    n_tests++;
    if (out_valid !== 1'b1 || out_pc !== RESET_PC || out_instr !== word_of(RESET_PC)) begin
      n_fail++;
      $display("FAIL bp_hold: valid=%b pc=%h instr=%h, want 1 %h %h",
               out_valid, out_pc, out_instr, RESET_PC, word_of(RESET_PC));
    end
    for (int i = 0; i < 4; i++) expect_word(RESET_PC + 32'(4 * i));
    ready_en = 1'b1;
    wait_drain("bp");
  endtask

  task automatic test_redirect();
    apply_reset();
    mem_lat = 3;
    wait_pending("redir");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_1003;
    iss_q.delete();
    @(posedge clk);
    #2;
    redirect_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || imem_read !== 1'b1 || imem_address !== RESET_PC) begin
      n_fail++;
      $display("FAIL redir_drain: valid=%b read=%b addr=%h, want 0 1 %h", out_valid, imem_read, imem_address, RESET_PC);
    end
    expect_word(32'h0000_1000);
    expect_word(32'h0000_1004);
    ready_en = 1'b1;
    wait_drain("redir");
    wait_iss(1, "redir");
    n_tests++;
    if (iss_q.size() == 0 || iss_q[0] !== 32'h0000_1000) begin
      n_fail++;
      $display("FAIL redir_addr: got %h, want 00001000", (iss_q.size() != 0) ? iss_q[0] : 32'hx);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    mem_lat = 1;
    wait_out_valid("coinc");
    mem_hold = 1'b1;
    wait_pending("coinc");
    mem_hold = 1'b0;
    @(posedge clk);
    #2;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2003;
    force_ready    = 1'b1;
    iss_q.delete();
    n_tests++;
    if (imem_resp !== 1'b1 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL coinc_setup: resp=%b valid=%b, want 1 1", imem_resp, out_valid);
    end
    @(posedge clk);
    #2;
    redirect_valid = 1'b0;
    force_ready    = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || imem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL coinc_flush: valid=%b read=%b, want 0 0", out_valid, imem_read);
    end
    expect_word(32'h0000_2000);
    expect_word(32'h0000_2004);
    ready_en = 1'b1;
    wait_drain("coinc");
    wait_iss(1, "coinc");
    n_tests++;
    if (iss_q.size() == 0 || iss_q[0] !== 32'h0000_2000) begin
      n_fail++;
      $display("FAIL coinc_addr: got %h, want 00002000", (iss_q.size() != 0) ? iss_q[0] : 32'hx);
    end
  endtask

  task automatic test_wrap();
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    ready_en = 1'b0;
    sb_q.delete();
    repeat (2) @(posedge clk);
    #2;
    mem_lat        = 1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    iss_q.delete();
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    redirect_valid = 1'b0;
    expect_word(32'hFFFF_FFFC);
    expect_word(32'h0000_0000);
    expect_word(32'h0000_0004);
    ready_en = 1'b1;
    wait_drain("wrap");
    wait_iss(2, "wrap");
    n_tests++;
    if (iss_q.size() < 2 || iss_q[0] !== 32'hFFFF_FFFC || iss_q[1] !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL wrap_addr: got %h %h, want fffffffc 00000000",
               (iss_q.size() > 0) ? iss_q[0] : 32'hx, (iss_q.size() > 1) ? iss_q[1] : 32'hx);
    end
  endtask

  task automatic test_reset_midreq();
    apply_reset();
    mem_lat = 3;
    wait_out_valid("midrst");
    wait_pending("midrst");
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (imem_read !== 1'b0 || imem_address !== RESET_PC || out_valid !== 1'b0 ||
        out_instr !== 32'h0 || out_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_async: read=%b addr=%h valid=%b instr=%h pc=%h, want 0 %h 0 0 0",
               imem_read, imem_address, out_valid, out_instr, out_pc, RESET_PC);
    end
    repeat (2) @(posedge clk);
    #2;
    iss_q.delete();
    sb_q.delete();
    rst_n = 1'b1;
    expect_word(RESET_PC);
    expect_word(RESET_PC + 32'd4);
    ready_en = 1'b1;
    wait_drain("midrst");
    wait_iss(1, "midrst");
    n_tests++;
    if (iss_q.size() == 0 || iss_q[0] !== RESET_PC) begin
      n_fail++;
      $display("FAIL midrst_refetch: got %h, want %h", (iss_q.size() != 0) ? iss_q[0] : 32'hx, RESET_PC);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_reset_midreq();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, want finished");
    $fatal(1, "timeout");
  end

endmodule
